// File: rtl/card_match_controller_pkg.sv
// Shared definitions for the card-flip memory game: FSM states and default
// board/timer parameters used by the controller and its benches.
package game_pkg;

  localparam int NUM_CARDS_DEF = 16;
  localparam int SEL_W_DEF     = 4;
  localparam int SYM_W_DEF     = 3;

  localparam logic [15:0] SHOW_DELAY_DEF  = 16'd100;
  localparam logic [15:0] MATCH_DELAY_DEF = 16'd50;

  typedef enum logic [2:0] {
    FIRST,
    SECOND,
    COMPARE,
    SHOW,
    DONE
  } state_t;

endpackage

// File: rtl/card_match_controller_if.sv
// Selection and timer handshake between the game controller, the player
// input logic and timer_module.
interface card_match_controller_if #(
  parameter int SEL_W = 4
);

  logic             sel_valid;
  logic [SEL_W-1:0] card_sel;
  logic             timer_done;
  logic             start_timer;
  logic [15:0]      delay;

  // master: player input and timer side; slave: the controller
  modport master (
    output sel_valid, card_sel, timer_done,
    input  start_timer, delay
  );

  modport slave (
    input  sel_valid, card_sel, timer_done,
    output start_timer, delay
  );

endinterface

// File: rtl/card_match_controller.sv
// Game-control FSM: reveals two selected cards, compares symbols, arms the
// external timer and retires or hides the pair when the timer completes.
module card_match_controller
  import game_pkg::*;
#(
  parameter int          NUM_CARDS   = NUM_CARDS_DEF,
  parameter int          SEL_W       = SEL_W_DEF,
  parameter int          SYM_W       = SYM_W_DEF,
  parameter logic [15:0] SHOW_DELAY  = SHOW_DELAY_DEF,
  parameter logic [15:0] MATCH_DELAY = MATCH_DELAY_DEF,
  localparam int         PAIR_W      = $clog2(NUM_CARDS/2 + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  card_match_controller_if.slave     bus,
  input  logic [NUM_CARDS*SYM_W-1:0] card_symbols,
  output logic [NUM_CARDS-1:0]       revealed,
  output logic [NUM_CARDS-1:0]       matched,
  output logic [PAIR_W-1:0]          pairs_found,
  output logic [7:0]                 attempts,
  output logic                       match_flag,
  output logic                       game_over
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_a, idx_a_d, idx_b, idx_b_d;
  logic               is_match_q, is_match_d;
  logic [NUM_CARDS-1:0] revealed_d, matched_d;
  logic [PAIR_W-1:0]  pairs_d;
  logic [7:0]         attempts_d;
  logic               match_flag_d, game_over_d;
  logic               start_timer_q, start_timer_d;
  logic [15:0]        delay_q, delay_d;
  logic               done_q;
  logic               timer_rise;
  logic               sel_legal;
  logic [SYM_W-1:0]   sym_a, sym_b;

  assign bus.start_timer = start_timer_q;
  assign bus.delay       = delay_q;

  assign timer_rise = bus.timer_done & ~done_q;
  assign sel_legal  = (int'(bus.card_sel) < NUM_CARDS) &&
                      !matched[bus.card_sel] && !revealed[bus.card_sel];
  assign sym_a = card_symbols[idx_a*SYM_W +: SYM_W];
  assign sym_b = card_symbols[idx_b*SYM_W +: SYM_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FIRST;
      idx_a         <= '0;
      idx_b         <= '0;
      is_match_q    <= 1'b0;
      revealed      <= '0;
      matched       <= '0;
      pairs_found   <= '0;
      attempts      <= '0;
      start_timer_q <= 1'b0;
      match_flag    <= 1'b0;
      game_over     <= 1'b0;
      delay_q       <= SHOW_DELAY;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_a         <= idx_a_d;
      idx_b         <= idx_b_d;
      is_match_q    <= is_match_d;
      revealed      <= revealed_d;
      matched       <= matched_d;
      pairs_found   <= pairs_d;
      attempts      <= attempts_d;
      start_timer_q <= start_timer_d;
      match_flag    <= match_flag_d;
      game_over     <= game_over_d;
      delay_q       <= delay_d;
      done_q        <= bus.timer_done;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_a_d       = idx_a;
    idx_b_d       = idx_b;
    is_match_d    = is_match_q;
    revealed_d    = revealed;
    matched_d     = matched;
    pairs_d       = pairs_found;
    attempts_d    = attempts;
    delay_d       = delay_q;
    start_timer_d = 1'b0;
    match_flag_d  = 1'b0;
    game_over_d   = game_over;

    unique case (state_q)
      FIRST: if (bus.sel_valid && sel_legal) begin
        idx_a_d                  = bus.card_sel;
        revealed_d[bus.card_sel] = 1'b1;
        state_d                  = SECOND;
      end
      SECOND: if (bus.sel_valid && sel_legal) begin
        idx_b_d                  = bus.card_sel;
        revealed_d[bus.card_sel] = 1'b1;
        state_d                  = COMPARE;
      end
      COMPARE: begin
        is_match_d    = (sym_a == sym_b);
        delay_d       = (sym_a == sym_b) ? MATCH_DELAY : SHOW_DELAY;
        start_timer_d = 1'b1;
        state_d       = SHOW;
      end
      SHOW: if (timer_rise) begin
        revealed_d[idx_a] = 1'b0;
        revealed_d[idx_b] = 1'b0;
        if (attempts != '1) attempts_d = attempts + 8'd1;
        state_d = FIRST;
        if (is_match_q) begin
          matched_d[idx_a] = 1'b1;
          matched_d[idx_b] = 1'b1;
          pairs_d          = pairs_found + PAIR_W'(1);
          match_flag_d     = 1'b1;
          // last pair: finish directly instead of returning to FIRST
          if (pairs_found == PAIR_W'(NUM_CARDS/2 - 1)) begin
            state_d     = DONE;
            game_over_d = 1'b1;
          end
        end
      end
      DONE: game_over_d = 1'b1;
      default: state_d = FIRST;
    endcase
  end

endmodule

// File: tb/tb_card_match_controller.sv
// Directed plus randomized bench for card_match_controller, checked each
// cycle against a behavioural model of the game rules.
module tb_card_match_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] card_symbols;
  logic [15:0] revealed, matched;
  logic [3:0]  pairs_found;
  logic [7:0]  attempts;
  logic        match_flag, game_over;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 = waiting first pick, 1 = waiting second,
  // 2 = compare cycle, 3 = waiting timer, 4 = game finished
  int          ph, pa, pb, m_pairs, m_att, m_delay;
  bit          m_match, m_start, m_mflag, m_prev;
  bit [15:0]   m_rev, m_mat;

  card_match_controller_if #(.SEL_W(4)) bus ();

  card_match_controller #(
    .NUM_CARDS(16),
    .SEL_W(4),
    .SYM_W(3),
    .SHOW_DELAY(16'd100),
    .MATCH_DELAY(16'd50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .card_symbols(card_symbols),
    .revealed(revealed),
    .matched(matched),
    .pairs_found(pairs_found),
    .attempts(attempts),
    .match_flag(match_flag),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input int cs);
    return cs < 16 && !m_mat[cs] && !m_rev[cs];
  endfunction

  function automatic void model_step(input bit r, input bit sv, input int cs, input bit td);
    bit rise;
    if (r) begin
      ph = 0; pa = 0; pb = 0; m_pairs = 0; m_att = 0; m_delay = 100;
      m_match = 0; m_start = 0; m_mflag = 0; m_prev = 0;
      m_rev = '0; m_mat = '0;
      return;
    end
    rise    = td && !m_prev;
    m_prev  = td;
    m_start = 0;
    m_mflag = 0;
    case (ph)
      0: if (sv && legal(cs)) begin pa = cs; m_rev[cs] = 1; ph = 1; end
      1: if (sv && legal(cs)) begin pb = cs; m_rev[cs] = 1; ph = 2; end
      2: begin
        m_match = (pa / 2) == (pb / 2);
        m_delay = m_match ? 50 : 100;
        m_start = 1;
        ph = 3;
      end
      3: if (rise) begin
        m_rev[pa] = 0;
        m_rev[pb] = 0;
        m_att = (m_att < 255) ? m_att + 1 : 255;
        ph = 0;
        if (m_match) begin
          m_mat[pa] = 1;
          m_mat[pb] = 1;
          m_pairs++;
          m_mflag = 1;
          if (m_pairs == 8) ph = 4;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_all();
    chk("revealed",    32'(revealed),        32'(m_rev));
    chk("matched",     32'(matched),         32'(m_mat));
    chk("pairs_found", 32'(pairs_found),     32'(m_pairs));
    chk("attempts",    32'(attempts),        32'(m_att));
    chk("start_timer", 32'(bus.start_timer), 32'(m_start));
    chk("delay",       32'(bus.delay),       32'(m_delay));
    chk("match_flag",  32'(match_flag),      32'(m_mflag));
    chk("game_over",   32'(game_over),       32'(ph == 4));
  endtask

  task automatic step(input bit r, input bit sv, input int cs, input bit td);
    reset          = r;
    bus.sel_valid  = sv;
    bus.card_sel   = 4'(cs);
    bus.timer_done = td;
    @(posedge clk);
    model_step(r, sv, cs, td);
    #1;
    check_all();
  endtask

  task automatic pick_pair(input int a, input int b, input bit td);
    step(0, 1, a, td);
    step(0, 1, b, td);
    step(0, 0, 0, td);
  endtask

  task automatic resolve();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  initial begin
    bit r, sv, td_r;
    int cs;

    for (int i = 0; i < 16; i++) card_symbols[i*3 +: 3] = 3'(i >> 1);
    bus.sel_valid = 0; bus.card_sel = '0; bus.timer_done = 0;
    td_r = 0;

    // reset held three cycles
    repeat (3) step(1, 0, 0, 0);
    chk("reset_delay", 32'(bus.delay), 32'd100);

    // matching pair 0/1
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("two_revealed", 32'(revealed), 32'h0003);
    step(0, 0, 0, 0);
    chk("match_delay", 32'(bus.delay), 32'd50);
    resolve();
    chk("first_matched", 32'(matched), 32'h0003);

    // mismatching pair 2/5, then leave timer_done high
    pick_pair(2, 5, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("mismatch_att", 32'(attempts), 32'd2);

    // matched card, repeated card, selection during SHOW, stale done level
    step(0, 1, 0, 1);
    step(0, 1, 3, 1);
    step(0, 1, 3, 1);
    chk("only_bit3", 32'(revealed), 32'h0008);
    step(0, 1, 2, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 3, 1);
    step(0, 0, 0, 1);
    chk("stale_done", 32'(revealed), 32'h000C);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // clear the board
    for (int p = 2; p < 8; p++) begin
      pick_pair(2 * p, 2 * p + 1, 0);
      resolve();
    end
    chk("all_matched", 32'(matched), 32'hFFFF);
    chk("over", 32'(game_over), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 1, i, i % 2);

    // reset while waiting on the timer
    step(1, 0, 0, 0);
    pick_pair(0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("reset_att", 32'(attempts), 32'd0);

    // randomized play
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 199) == 0) || (ph == 4 && $urandom_range(0, 9) == 0);
      sv = 1'($urandom_range(0, 1));
      cs = int'($urandom_range(0, 15));
      if (ph == 1 && $urandom_range(0, 2) != 0) cs = pa ^ 1;
      if ($urandom_range(0, 4) == 0) td_r = ~td_r;
      step(r, sv, cs, td_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/card_match_controller.md
Name: card_match_controller

Overview:
- Game-control FSM for the card-flip memory game; sits directly upstream of timer_module and drives its start_timer/delay inputs while consuming its timer_done output.
- Accepts player card selections, reveals two cards, and compares their symbols.
- Holds both cards visible for a timed interval, then either retires them as a matched pair or hides them again.
- Tracks matched cards, pairs found, attempts, and game-over.

Parameters:
- NUM_CARDS, 16, number of cards on the board (even, ≤ 2^SEL_W).
- SEL_W, 4, card index width.
- SYM_W, 3, card symbol width.
- SHOW_DELAY, 16'd100, timer delay in cycles after a mismatch.
- MATCH_DELAY, 16'd50, timer delay in cycles after a match.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- sel_valid  in  1  one-cycle pulse; card_sel is valid.
- card_sel  in  SEL_W  index of the selected card.
- card_symbols  in  NUM_CARDS*SYM_W  symbol of card i at [i*SYM_W +: SYM_W]; held static during a game.
- timer_done  in  1  done level from timer_module.
- start_timer  out  1  one-cycle pulse to timer_module.
- delay  out  16  delay to timer_module; held stable between pulses.
- revealed  out  NUM_CARDS  cards currently face-up and unmatched.
- matched  out  NUM_CARDS  cards already retired as pairs.
- pairs_found  out  PAIR_W  count of matched pairs; PAIR_W = $clog2(NUM_CARDS/2+1).
- attempts  out  8  completed pair attempts; saturates at 255.
- match_flag  out  1  one-cycle pulse when a pair resolves as a match.
- game_over  out  1  high once all pairs are found.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = FIRST.
  - revealed, matched, pairs_found, attempts = 0.
  - start_timer, match_flag, game_over = 0.
  - delay = SHOW_DELAY.
  - done_q (registered timer_done) = 0.
  - Latched indices = 0.
- A selection is legal when all hold:
  - card_sel < NUM_CARDS;
  - matched[card_sel] = 0;
  - revealed[card_sel] = 0.
- Illegal selections, and any sel_valid outside FIRST/SECOND, are silently ignored.
- States:
  - FIRST: on legal sel_valid in cycle N, latch idx_a, set revealed[idx_a] at edge N+1, go to SECOND.
  - SECOND: on legal sel_valid, latch idx_b, set revealed[idx_b], go to COMPARE. The same card twice is illegal because it is already revealed.
  - COMPARE (exactly one cycle):
    - is_match = (sym[idx_a] == sym[idx_b]).
    - Register delay = MATCH_DELAY if is_match, else SHOW_DELAY.
    - Pulse start_timer for one cycle, aligned with the new delay value.
    - Go to SHOW.
    - start_timer therefore rises two edges after the second sel_valid.
  - SHOW:
    - Wait for a timer_done rising edge (timer_done & ~done_q). A level left high from a previous run is ignored.
    - On that edge, clear revealed[idx_a] and revealed[idx_b], and increment attempts (saturating).
    - If is_match:
      - set matched[idx_a] and matched[idx_b];
      - increment pairs_found;
      - pulse match_flag for one cycle.
    - If pairs_found reaches NUM_CARDS/2 on this update, go to DONE; else go to FIRST.
  - DONE: game_over = 1. All inputs ignored until reset.
- timer_done edges outside SHOW are ignored, but done_q still tracks timer_done every cycle.
- sel_valid coincident with a timer_done edge in SHOW: the selection is dropped.
- Reset in any state, including mid-SHOW: return to reset values on the next edge. A timer_done edge arriving after reset (in FIRST) has no effect.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package game_pkg holds:
  - state enum/localparams: FIRST, SECOND, COMPARE, SHOW, DONE;
  - NUM_CARDS, SEL_W, SYM_W defaults;
  - SHOW_DELAY and MATCH_DELAY constants, shared with top level and benches.
- No sub-module. The rising-edge detect on timer_done is a single in-module register.
- timer_module is instantiated beside this block at top level, not inside it.

Test Plan:
All scenarios use card_symbols with symbol(i) = i>>1, so pairs are (0,1), (2,3), … (14,15). timer_module is a bench model.
- Reset held 3 cycles -> all outputs zero, delay = 100, state FIRST.
- Select 0 then 1 -> revealed = 0x0003; start_timer pulses once 2 edges after the 2nd select with delay = 50; on timer_done rise, revealed = 0, matched = 0x0003, pairs_found = 1, attempts = 1, match_flag pulses for 1 cycle.
- Select 2 then 5 -> delay = 100; on timer_done rise, revealed = 0, matched unchanged, attempts = 2, no match_flag.
- Select 0 (matched), then 3 twice, then index 3 during SHOW -> the first 0 and the repeated 3 are ignored, revealed shows only bit 3 until the second card; sel_valid in SHOW causes no change. Also hold timer_done high into the next SHOW -> no resolution until it drops and rises again.
- Match all 8 pairs -> pairs_found = 8, game_over = 1, matched = 0xFFFF; further sel_valid and timer_done have no effect.
- Assert reset during SHOW, then raise timer_done -> all state cleared; no match_flag, attempts stays 0.
